snn_config_bank: RTL and testbench
==================================

Name: snn_config_bank

Overview:
- Parametrised, double-buffered configuration store for the SNN datapath. It replaces the fixed flat byte map with an addressed, framed byte protocol.
- Consumes bytes already deserialised and synchronised into the system_clock domain. Writes them into a shadow bank and atomically commits the shadow to an active bank that drives the network.
- Supports addressed burst write, burst readback of the active bank, commit, and a sticky error status.

Parameters:
- NUM_BYTES, 128, number of configuration bytes in each bank.
- ADDR_W, 8, address/length field width in bits; 2**ADDR_W >= NUM_BYTES is required.

Ports:
- system_clock  in  1  block clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- frame_end  in  1  one-cycle pulse on SS deassertion; aborts any frame in progress.
- tx_valid  out  1  readback byte available.
- tx_data  out  8  readback byte.
- tx_ready  in  1  consumer accepts tx_data this cycle.
- config_out  out  NUM_BYTES*8  active bank; byte k sits at bits [8k+7:8k].
- commit_pulse  out  1  one-cycle pulse when the shadow bank has been copied to active.
- error  out  1  sticky protocol error flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high, system_clock edge):
  - Shadow and active banks cleared to 0. FSM returns to IDLE.
  - tx_valid=0, tx_data=0, commit_pulse=0, error=0, busy=0.
  - Reset mid-frame discards the frame with no partial effect beyond bytes already written.
- FSM states: IDLE, ADDR, LEN, WDATA, RDATA.
- IDLE: an rx_valid byte is the command.
  - 0x01 WRITE -> ADDR.
  - 0x02 READ -> ADDR.
  - 0x03 COMMIT: all NUM_BYTES copy shadow->active in one cycle; commit_pulse=1 on the next cycle; stays IDLE.
  - 0x04 CLRERR: error<=0; stays IDLE.
  - Any other value: error<=1; stays IDLE.
- ADDR: next byte latched as start address (low ADDR_W bits) -> LEN.
- LEN: next byte is the count N.
  - N=0 -> IDLE, no effect.
  - Otherwise -> WDATA for WRITE, RDATA for READ.
- WDATA:
  - Each rx_valid byte is written to shadow[addr]; addr increments and N decrements.
  - After the Nth byte -> IDLE.
  - addr >= NUM_BYTES: byte dropped, error<=1, no wrap-around. Counting continues so framing stays aligned.
- RDATA:
  - tx_valid rises the cycle after the LEN byte; tx_data = active[addr].
  - On tx_valid & tx_ready: addr++, N--, and the next byte is presented the following cycle (one byte per two cycles maximum).
  - tx_valid and tx_data stay stable while tx_ready=0.
  - After the Nth handshake: tx_valid=0 -> IDLE.
  - addr >= NUM_BYTES: tx_data=0x00 and error<=1.
  - rx_valid bytes in RDATA are ignored.
- frame_end in any non-IDLE state: -> IDLE next cycle and tx_valid<=0.
  - Shadow bytes already written are retained.
  - If frame_end and rx_valid coincide, frame_end wins and the byte is discarded.
- config_out changes only on commit: shadow writes are invisible until a COMMIT command.
- Readback always returns the active bank, not the shadow.
- busy = (state != IDLE).

Test Plan:
- Reset, then write 0x01,0x05,0x02,0xAA,0xBB; check config_out unchanged (all 0). Send 0x03; check commit_pulse exactly 1 cycle and config_out bytes 5,6 = 0xAA,0xBB.
- After the above, send 0x02,0x05,0x02 with tx_ready toggling 1,0,1 -> tx_data 0xAA then 0xBB, held stable while tx_ready=0; tx_valid low after 2 handshakes; busy returns to 0.
- Write 0x01, addr NUM_BYTES-1, len 0x02, data 0x11,0x22 -> shadow[NUM_BYTES-1]=0x11; 0x22 dropped; error=1. Then 0x04 -> error=0.
- Send command 0x7F -> error=1, state remains IDLE. Then 0x01,0x00,0x00 (len 0) -> immediate IDLE, no write.
- Write 0x01,0x10,0x04,0x33, then pulse frame_end in the same cycle as byte 0x44 -> shadow[0x10]=0x33, 0x44 discarded, FSM IDLE; the next 0x03 commits only 0x33.
- Assert reset mid-RDATA -> tx_valid=0, both banks zero, busy=0 on the next cycle.

Source files
------------

// File: rtl/snn_config_bank.sv
// snn_config_bank: double-buffered SNN configuration store.
// Framed byte protocol: write/read bursts, commit, sticky error.
module snn_config_bank #(
  parameter int NUM_BYTES = 128,
  parameter int ADDR_W    = 8
) (
  input  logic                   system_clock,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   frame_end,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [NUM_BYTES*8-1:0] config_out,
  output logic                   commit_pulse,
  output logic                   error,
  output logic                   busy
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [ADDR_W:0] NB = NUM_BYTES[ADDR_W:0];

  typedef enum logic [2:0] {
    IDLE, ADDR, LEN, WDATA, RDATA
  } state_t;

  state_t state_q, state_d;

  logic [NUM_BYTES*8-1:0] shadow_q;
  logic [NUM_BYTES*8-1:0] active_q;
  // One spare bit so a burst running past the top never wraps to 0.
  logic [ADDR_W:0]        addr_q;
  logic [ADDR_W-1:0]      cnt_q;
  logic                   rd_q;

  logic              rx_ok;
  logic              in_range;
  logic [IW-1:0]     idx;
  logic [ADDR_W-1:0] len_in;

  logic cmd_commit, cmd_clr, cmd_bad;
  logic ld_addr, ld_len, wr_en, present, hs;

  assign rx_ok      = rx_valid && !frame_end;
  assign in_range   = addr_q < NB;
  assign idx        = addr_q[IW-1:0];
  assign len_in     = ADDR_W'(rx_data);
  assign busy       = state_q != IDLE;
  assign config_out = active_q;

  always_ff @(posedge system_clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_commit = 1'b0;
    cmd_clr    = 1'b0;
    cmd_bad    = 1'b0;
    ld_addr    = 1'b0;
    ld_len     = 1'b0;
    wr_en      = 1'b0;
    present    = 1'b0;
    hs         = 1'b0;
    unique case (state_q)
      IDLE: if (rx_valid) begin
        unique case (1'b1)
          (rx_data == 8'h01),
          (rx_data == 8'h02): state_d    = ADDR;
          (rx_data == 8'h03): cmd_commit = 1'b1;
          (rx_data == 8'h04): cmd_clr    = 1'b1;
          default:            cmd_bad    = 1'b1;
        endcase
      end
      ADDR: if (rx_ok) begin
        ld_addr = 1'b1;
        state_d = LEN;
      end
      LEN: if (rx_ok) begin
        ld_len = 1'b1;
        if (len_in == '0) begin
          state_d = IDLE;
        end else begin
          state_d = rd_q ? RDATA : WDATA;
          present = rd_q;
        end
      end
      WDATA: if (rx_ok) begin
        wr_en = 1'b1;
        if (cnt_q == ADDR_W'(1)) state_d = IDLE;
      end
      RDATA: if (!frame_end) begin
        if (tx_valid && tx_ready) begin
          hs = 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = IDLE;
        end else if (!tx_valid) begin
          present = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_end && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      shadow_q     <= '0;
      active_q     <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      commit_pulse <= 1'b0;
      error        <= 1'b0;
    end else begin
      commit_pulse <= cmd_commit;
      if (cmd_commit) active_q <= shadow_q;
      if (cmd_clr)    error    <= 1'b0;
      if (cmd_bad)    error    <= 1'b1;
      if (state_q == IDLE && rx_valid) rd_q <= rx_data == 8'h02;
      if (ld_addr) addr_q <= {1'b0, ADDR_W'(rx_data)};
      if (ld_len)  cnt_q  <= len_in;
      if (wr_en) begin
        if (in_range) shadow_q[{idx, 3'b000} +: 8] <= rx_data;
        else          error <= 1'b1;
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
      if (present) begin
        tx_valid <= 1'b1;
        tx_data  <= in_range ? active_q[{idx, 3'b000} +: 8] : 8'h00;
        if (!in_range) error <= 1'b1;
      end
      if (hs) begin
        tx_valid <= 1'b0;
        addr_q   <= addr_q + 1'b1;
        cnt_q    <= cnt_q - 1'b1;
      end
      if (frame_end && state_q != IDLE) tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_config_bank.sv
// tb_snn_config_bank: directed, table and random checks
// of snn_config_bank against a byte-array model.
module tb_snn_config_bank;

  localparam int NB = 128;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            frame_end;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [NB*8-1:0] config_out;
  logic            commit_pulse;
  logic            error;
  logic            busy;

  always #5 clk = ~clk;

  snn_config_bank #(.NUM_BYTES(NB), .ADDR_W(AW)) dut (
    .system_clock(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .frame_end(frame_end),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .config_out(config_out),
    .commit_pulse(commit_pulse),
    .error(error),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] shadow_m [NB];
  logic [7:0] active_m [NB];
  logic       err_m;

  typedef struct {
    logic [7:0] cmd;
    logic       exp_err;
    logic       exp_pulse;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_cfg(input string name);
    int bad;
    bad = -1;
    for (int k = 0; k < NB; k++)
      if (bad < 0 && config_out[k*8 +: 8] !== active_m[k]) bad = k;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: config byte %0d got %0h expected %0h",
               name, bad, config_out[bad*8 +: 8], active_m[bad]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) begin
      shadow_m[k] = 8'h00;
      active_m[k] = 8'h00;
    end
    err_m = 1'b0;
  endtask

  // cut < d.size(): byte d[cut] coincides with frame_end and is lost
  task automatic wr_burst(input int a, input logic [7:0] d[$],
                          input int cut);
    send(8'h01);
    send(8'(a));
    send(8'(d.size()));
    for (int i = 0; i < d.size(); i++) begin
      if (i == cut) begin
        rx_valid  = 1'b1;
        rx_data   = d[i];
        frame_end = 1'b1;
        step();
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        break;
      end
      send(d[i]);
      if (a + i < NB) shadow_m[a + i] = d[i];
      else            err_m = 1'b1;
    end
  endtask

  task automatic do_commit();
    send(8'h03);
    for (int k = 0; k < NB; k++) active_m[k] = shadow_m[k];
    chk("commit_pulse_hi", commit_pulse, 1);
    chk_cfg("commit_cfg");
    step();
    chk("commit_pulse_lo", commit_pulse, 0);
  endtask

  task automatic rd_burst(input int a, input int n,
                          input int lo, input int hi);
    logic [7:0] exp;
    int k;
    int st;
    send(8'h02);
    send(8'(a));
    send(8'(n));
    chk("rd_first_valid", tx_valid, 1);
    for (int i = 0; i < n; i++) begin
      if (a + i < NB) exp = active_m[a + i];
      else begin
        exp   = 8'h00;
        err_m = 1'b1;
      end
      k = 0;
      while (!tx_valid && k < 4) begin
        step();
        k++;
      end
      chk("rd_valid", tx_valid, 1);
      chk("rd_data", tx_data, exp);
      st = $urandom_range(hi, lo);
      repeat (st) begin
        tx_ready = 1'b0;
        step();
        chk("rd_hold", {tx_valid, tx_data}, {1'b1, exp});
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    chk("rd_end_valid", tx_valid, 0);
    chk("rd_end_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    int a;
    int n;
    int op;

    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    frame_end = 1'b0;
    tx_ready  = 1'b0;
    model_clear();
    step();
    step();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_pulse", commit_pulse, 0);
    chk("rst_error", error, 0);
    chk("rst_busy", busy, 0);
    chk_cfg("rst_cfg");
    reset = 1'b0;
    step();

    // shadow writes stay hidden until commit
    d = '{8'hAA, 8'hBB};
    wr_burst(5, d, 99);
    chk("wr_busy", busy, 0);
    chk_cfg("hidden_cfg");
    do_commit();
    chk("cfg_b5", config_out[5*8 +: 8], 8'hAA);
    chk("cfg_b6", config_out[6*8 +: 8], 8'hBB);

    rd_burst(5, 2, 1, 1);
    chk("rd_err", error, 0);

    // write crossing the top: last byte dropped, error raised
    d = '{8'h11, 8'h22};
    wr_burst(NB - 1, d, 99);
    chk("oob_err", error, 1);
    do_commit();
    chk("cfg_top", config_out[(NB-1)*8 +: 8], 8'h11);
    send(8'h04);
    err_m = 1'b0;
    chk("clrerr", error, 0);

    send(8'h7F);
    chk("bad_cmd_err", error, 1);
    chk("bad_cmd_busy", busy, 0);
    send(8'h04);
    err_m = 1'b0;

    send(8'h01);
    send(8'h00);
    send(8'h00);
    chk("len0_busy", busy, 0);
    do_commit();

    d = '{8'h33, 8'h44, 8'h55, 8'h66};
    wr_burst(16, d, 1);
    chk("abort_busy", busy, 0);
    chk("abort_txv", tx_valid, 0);
    do_commit();
    chk("abort_b16", config_out[16*8 +: 8], 8'h33);
    chk("abort_b17", config_out[17*8 +: 8], 8'h00);

    // read of unmapped addresses returns zero
    rd_burst(NB - 1, 3, 0, 1);
    chk("rd_oob_err", error, err_m);
    send(8'h04);
    err_m = 1'b0;

    tbl.push_back('{8'h7F, 1'b1, 1'b0});
    tbl.push_back('{8'h04, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 1'b0});
    tbl.push_back('{8'h03, 1'b1, 1'b1});
    tbl.push_back('{8'h04, 1'b0, 1'b0});
    tbl.push_back('{8'h05, 1'b1, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0});
    tbl.push_back('{8'h04, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 1'b0, 1'b1});
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].cmd);
      chk("tbl_err", error, tbl[i].exp_err);
      chk("tbl_pulse", commit_pulse, tbl[i].exp_pulse);
      chk("tbl_busy", busy, 0);
      err_m = tbl[i].exp_err;
      if (tbl[i].cmd == 8'h03) begin
        for (int k = 0; k < NB; k++) active_m[k] = shadow_m[k];
        chk_cfg("tbl_cfg");
      end
    end

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(4, 0);
      if ($urandom_range(1, 0) == 1) a = $urandom_range(NB - 1, 0);
      else                           a = $urandom_range(255, NB - 8);
      case (op)
        0, 1: begin
          n = $urandom_range(6, 2);
          d = {};
          for (int i = 0; i < n; i++) d.push_back(8'($urandom));
          wr_burst(a, d, (op == 1) ? $urandom_range(n - 1, 0) : 99);
        end
        2: do_commit();
        3: rd_burst(a, $urandom_range(5, 1), 0, 2);
        default: begin
          send(8'h04);
          err_m = 1'b0;
        end
      endcase
      chk("rnd_err", error, err_m);
      chk("rnd_busy", busy, 0);
    end
    do_commit();

    // reset in the middle of a readback
    send(8'h02);
    send(8'h05);
    send(8'h03);
    chk("pre_rst_txv", tx_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    chk("mid_rst_txv", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", error, 0);
    chk_cfg("mid_rst_cfg");
    do_commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
